// File: rtl/branch_lut_writer.sv
// Loadable 64 x 7 branch-target table with a byte-stream command port.
// Fetch reads the table combinationally; CLEAR sweeps one entry per cycle.
module branch_lut_writer #(
  parameter int DEPTH = 64,
  parameter int TW    = 7
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [TW-1:0]            rd_target,
  output logic                     busy,
  output logic [6:0]               wr_count,
  output logic                     err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    GET_TGT,
    CLEAR
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0] tbl [DEPTH];
  logic [IW-1:0] idx_q;
  logic [IW-1:0] ptr;
  logic          fire;
  logic [1:0]    op;
  logic          last;

  assign fire = in_valid && in_ready;
  assign op   = in_data[7:6];
  assign last = (ptr == IW'(DEPTH - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (fire) begin
          unique case (op)
            2'b00:   state_nx = GET_TGT;
            2'b01:   state_nx = CLEAR;
            default: state_nx = IDLE;
          endcase
        end
      end
      GET_TGT: if (fire) state_nx = IDLE;
      CLEAR:   if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != CLEAR);
    busy     = (state != IDLE);
  end

  // Table and bookkeeping; ptr wraps to 0 naturally on the final sweep write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      idx_q    <= '0;
      ptr      <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            unique case (op)
              2'b00:   idx_q <= in_data[IW-1:0];
              2'b01:   ptr   <= '0;
              2'b11:   err   <= 1'b1;
              default: ;
            endcase
          end
        end
        GET_TGT: begin
          if (fire) begin
            if (!in_data[7]) begin
              tbl[idx_q] <= in_data[TW-1:0];
              if (wr_count != 7'h7F)
                wr_count <= wr_count + 7'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          tbl[ptr] <= '0;
          ptr      <= ptr + IW'(1);
          if (last) begin
            wr_count <= '0;
            err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_target = tbl[rd_index];

endmodule
